rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (RegWrite/rd/WriteData) between two writeback sources.
- Source A is the in-order pipeline writeback. Source B is the long-latency unit (mul/div, multi-cycle load).
- Fixed priority to A, with a starvation guard that forces a B grant after MAX_WAIT blocked cycles.
- Keeps a pending-write scoreboard of outstanding B destinations; the hazard unit uses it to stall dependent reads.

Parameters:
- XLEN, 32, data width of write port.
- MAX_WAIT, 4, consecutive blocked B cycles before a forced B grant (must be >= 1).
- CNT_W, $clog2(MAX_WAIT+1), wait-counter width (derived; do not override).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_valid  in  1  pipeline writeback request.
- a_ready  out  1  A accepted this cycle when a_valid && a_ready.
- a_rd  in  5  A destination register.
- a_data  in  XLEN  A write data.
- b_valid  in  1  long-latency unit result request.
- b_ready  out  1  B accepted this cycle when b_valid && b_ready.
- b_rd  in  5  B destination register.
- b_data  in  XLEN  B write data.
- iss_valid  in  1  long-latency op issued this cycle.
- iss_rd  in  5  destination of issued op.
- rf_we  out  1  to register file RegWrite.
- rf_rd  out  5  to register file rd.
- rf_wdata  out  XLEN  to register file WriteData.
- pending  out  32  bit i = write to x(i) outstanding from B.
- b_starve  out  1  high while in FORCE_B.

Behaviour:
- Reset (async, rst=1): state=NORMAL, wait_cnt=0, rf_we=0, rf_rd=0, rf_wdata=0, pending=0, b_starve=0. Outputs hold reset values for as long as rst=1. An in-flight handshake at reset assertion is dropped.
- FSM state NORMAL:
  - a_ready=1; b_ready=!a_valid.
  - wait_cnt increments on each cycle with b_valid && !b_ready.
  - wait_cnt clears on a B handshake or when b_valid=0.
  - A blocked cycle with wait_cnt==MAX_WAIT-1 transitions to FORCE_B at the next edge.
- FSM state FORCE_B:
  - a_ready=0, b_ready=1, b_starve=1.
  - On B handshake: go to NORMAL, wait_cnt=0.
  - If b_valid drops (protocol violation), return to NORMAL with wait_cnt=0.
- Ready outputs are combinational from state and a_valid only. They never depend on b_valid.
- Sources hold valid/rd/data stable until their handshake.
- Write stage (registered, latency 1):
  - On any handshake at edge N: rf_we=(rd!=0), rf_rd=rd, rf_wdata=data during cycle N+1.
  - With no handshake, rf_we=0, and rf_rd/rf_wdata hold their previous values.
  - At most one handshake per cycle by construction.
- A write to x0 is accepted (handshake completes) but rf_we stays 0.
- Scoreboard:
  - iss_valid && iss_rd!=0 sets pending[iss_rd] at the edge.
  - A B handshake clears pending[b_rd] at the same edge that registers the write. pending drops in the cycle rf_we drives the write, so the register file write-to-read bypass supplies the value.
  - Set and clear of the same bit in one cycle: set wins (new producer).
  - pending[0] is constantly 0.
  - A handshakes never touch pending.
- Wait counter saturates at MAX_WAIT-1; no wrap.

Test Plan:
- Reset mid-operation: assert rst during a FORCE_B cycle with pending=0x0000_0030 -> same cycle rf_we=0, pending=0, b_starve=0, a_ready=1.
- A only: a_valid=1, a_rd=5, a_data=0xDEADBEEF -> next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; b_ready=0 while a_valid=1.
- Starvation, MAX_WAIT=4: a_valid and b_valid held high from cycle 0, b_rd=7, b_data=0x1234 ->
  - b_ready=0 in cycles 0-3.
  - Cycle 4: b_starve=1, a_ready=0, B handshake.
  - Cycle 5: rf_we=1, rf_rd=7, rf_wdata=0x1234; a_ready=1.
- Scoreboard lifecycle:
  - iss_valid, iss_rd=9 -> pending=0x200 next cycle.
  - B handshake with b_rd=9 -> pending=0 in the same cycle rf_we=1, rf_rd=9.
- Simultaneous set/clear: iss_rd=9 and B handshake b_rd=9 in the same cycle -> pending[9]=1 afterwards. iss_rd=0 -> pending unchanged.
- x0 write: B handshake with b_rd=0 -> b_ready=1 handshake completes, rf_we=0 next cycle, wait_cnt=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Shares the register-file write port between the pipeline writeback (A) and the
// long-latency unit (B), with a starvation guard for B and a pending-write scoreboard.
module rf_wb_arbiter #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic [31:0]     pending,
    output logic            b_starve
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic {
        NORMAL,
        FORCE_B
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [4:0]        rf_rd_q, rf_rd_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;
    logic [31:0]       pending_q, pending_d;
    logic              a_hs, b_hs;

    // Readies depend only on state and a_valid, never on b_valid.
    always_comb begin
        a_ready  = (state_q == NORMAL);
        b_ready  = (state_q == FORCE_B) || !a_valid;
        b_starve = (state_q == FORCE_B);
    end

    assign a_hs = a_valid && a_ready;
    assign b_hs = b_valid && b_ready;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            NORMAL: begin
                if (b_valid && !b_ready) begin
                    if (wait_cnt_q == WAIT_LAST) begin
                        state_d = FORCE_B;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end
            FORCE_B: begin
                wait_cnt_d = '0;
                if (b_hs || !b_valid) begin
                    state_d = NORMAL;
                end
            end
        endcase
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_rd_d    = rf_rd_q;
        rf_wdata_d = rf_wdata_q;
        if (a_hs) begin
            rf_we_d    = (a_rd != 5'd0);
            rf_rd_d    = a_rd;
            rf_wdata_d = a_data;
        end else if (b_hs) begin
            rf_we_d    = (b_rd != 5'd0);
            rf_rd_d    = b_rd;
            rf_wdata_d = b_data;
        end
    end

    // Clear first so a same-cycle issue to the same register (a new producer) wins.
    always_comb begin
        pending_d = pending_q;
        if (b_hs) begin
            pending_d[b_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            pending_d[iss_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= NORMAL;
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_wdata_q <= '0;
            pending_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            pending_q  <= pending_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;
    assign pending  = pending_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomised scoreboard bench for rf_wb_arbiter: a behavioural arbiter model predicts
// readies, grants and pending bits; a negedge monitor checks the register-file port.
module tb_rf_wb_arbiter;

    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            a_valid, a_ready;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_data;
    logic            b_valid, b_ready;
    logic [4:0]      b_rd;
    logic [XLEN-1:0] b_data;
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic [31:0]     pending;
    logic            b_starve;

    rf_wb_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .pending(pending), .b_starve(b_starve)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          cyc = 0;
    int          tests_run = 0;
    int          tests_failed = 0;
    bit          mon_en = 1'b0;
    logic [4:0]  exp_rd = 5'd0;
    logic [31:0] exp_data = 32'd0;

    // Reference model: B is forced once it has been refused MAX_WAIT cycles in a row.
    bit          force_b = 1'b0;
    int          blocked = 0;
    logic [31:0] exp_pend = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic applyStimulus(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                                 input bit bv, input logic [4:0] br, input logic [31:0] bd,
                                 input bit iv, input logic [4:0] ir,
                                 output bit a_hs, output bit b_hs);
        bit  exp_a_ready, exp_b_ready;
        wr_t w;
        a_valid = av; a_rd = ar; a_data = ad;
        b_valid = bv; b_rd = br; b_data = bd;
        iss_valid = iv; iss_rd = ir;
        #1;
        exp_a_ready = !force_b;
        exp_b_ready = force_b || !av;
        checkOutput("a_ready", a_ready, exp_a_ready);
        checkOutput("b_ready", b_ready, exp_b_ready);
        checkOutput("b_starve", b_starve, force_b);
        a_hs = av && exp_a_ready;
        b_hs = bv && exp_b_ready;
        if (a_hs) begin
            w.due = cyc + 1; w.we = (ar != 5'd0); w.rd = ar; w.data = ad;
            exp_q.push_back(w);
        end else if (b_hs) begin
            w.due = cyc + 1; w.we = (br != 5'd0); w.rd = br; w.data = bd;
            exp_q.push_back(w);
        end
        if (force_b) begin
            force_b = 1'b0;
            blocked = 0;
        end else if (bv && !b_hs) begin
            blocked++;
            if (blocked >= MAX_WAIT) force_b = 1'b1;
        end else begin
            blocked = 0;
        end
        if (b_hs) exp_pend[br] = 1'b0;
        if (iv && ir != 5'd0) exp_pend[ir] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("pending", pending, exp_pend);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin : monitor
            wr_t  w;
            logic exp_we;
            exp_we = 1'b0;
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                w        = exp_q.pop_front();
                exp_we   = w.we;
                exp_rd   = w.rd;
                exp_data = w.data;
            end
            checkOutput("rf_we", rf_we, exp_we);
            checkOutput("rf_rd", rf_rd, exp_rd);
            checkOutput("rf_wdata", rf_wdata, exp_data);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit          ah, bh, av, bv, iv;
        logic [4:0]  ar, br, ir;
        logic [31:0] ad, bd;

        rst = 1'b1;
        a_valid = 0; a_rd = 0; a_data = 0;
        b_valid = 0; b_rd = 0; b_data = 0;
        iss_valid = 0; iss_rd = 0;
        #2;
        checkOutput("reset_rf_we", rf_we, 0);
        checkOutput("reset_rf_rd", rf_rd, 0);
        checkOutput("reset_rf_wdata", rf_wdata, 0);
        checkOutput("reset_pending", pending, 0);
        checkOutput("reset_b_starve", b_starve, 0);
        checkOutput("reset_a_ready", a_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0, 5'd0, ah, bh);
        applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, ah, bh);

        applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9, ah, bh);
        applyStimulus(0, 5'd0, 32'd0, 1, 5'd9, 32'hCAFE0009, 0, 5'd0, ah, bh);
        applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd9, ah, bh);
        applyStimulus(0, 5'd0, 32'd0, 1, 5'd9, 32'h00000099, 1, 5'd9, ah, bh);
        applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd0, ah, bh);
        applyStimulus(0, 5'd0, 32'd0, 1, 5'd9, 32'h99990000, 0, 5'd0, ah, bh);

        applyStimulus(0, 5'd0, 32'd0, 1, 5'd0, 32'h0BADF00D, 0, 5'd0, ah, bh);
        applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, ah, bh);

        bh = 1'b0;
        for (int k = 0; k < 10 && !bh; k++) begin
            applyStimulus(1, 5'(k + 1), 32'h100 + k, 1, 5'd7, 32'h1234, 0, 5'd0, ah, bh);
        end
        applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, ah, bh);

        // Drive into FORCE_B with bits 4 and 5 pending, then reset asynchronously.
        applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd4, ah, bh);
        applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd5, ah, bh);
        for (int k = 0; k < 10 && !force_b; k++) begin
            applyStimulus(1, 5'(k + 3), 32'hA0 + k, 1, 5'd7, 32'h55, 0, 5'd0, ah, bh);
        end
        mon_en = 1'b0;
        checkOutput("pre_reset_b_starve", b_starve, 1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_rf_we", rf_we, 0);
        checkOutput("midrst_pending", pending, 0);
        checkOutput("midrst_b_starve", b_starve, 0);
        checkOutput("midrst_a_ready", a_ready, 1);
        checkOutput("midrst_rf_rd", rf_rd, 0);
        a_valid = 0; b_valid = 0; iss_valid = 0;
        exp_q.delete();
        force_b = 1'b0; blocked = 0; exp_pend = 32'd0;
        exp_rd = 5'd0; exp_data = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        av = 0; bv = 0; ah = 0; bh = 0;
        ar = 0; br = 0; ad = 0; bd = 0;
        for (int n = 0; n < 600; n++) begin
            if (!av || ah) begin
                av = ($urandom_range(0, 9) < 7);
                ar = 5'($urandom_range(0, 31));
                ad = $urandom;
            end
            if (!bv || bh) begin
                bv = ($urandom_range(0, 1) == 1);
                br = 5'($urandom_range(0, 15));
                bd = $urandom;
            end
            iv = ($urandom_range(0, 3) == 0);
            ir = 5'($urandom_range(0, 15));
            applyStimulus(av, ar, ad, bv, br, bd, iv, ir, ah, bh);
        end
        applyStimulus(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, ah, bh);
        @(negedge clk);
        #1;
        checkOutput("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
